// File: rtl/dma_pkg.sv
// Shared DMA word and byte-lane definitions used by the packer and the DMA write engine.
package dma_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

  typedef logic [WORD_BYTES*BYTE_W-1:0] dma_word_t;
  typedef logic [IDX_W-1:0]             lane_idx_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic show-ahead FIFO: head word is presented combinationally from the memory array.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;
  // Gate the head so stale memory never leaks out while empty.
  assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(wr_en && full)) else $error("sync_fifo_fwft: write attempted while full");
      assert (r_count <= CNT_W'(DEPTH)) else $error("sync_fifo_fwft: occupancy out of range");
    end
  end

endmodule

// File: rtl/dma_byte_pack_fifo.sv
// Packs an 8-bit valid/ready/last stream little-endian into 32-bit words feeding a show-ahead FIFO.
module dma_byte_pack_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] o_fifo_rdata,
  output logic                  o_fifo_empty,
  input  logic                  i_fifo_ren,
  output logic [CNT_W-1:0]      o_fifo_count,
  output logic                  o_pad_err
);

  lane_idx_t r_byte_idx;
  dma_word_t r_pack;
  logic      r_pad_err;
  dma_word_t w_word;
  logic      w_full;
  logic      w_accept;
  logic      w_idx_last;
  logic      w_complete;

  // Ready depends only on registered occupancy and flush, never on tvalid/tlast.
  assign s_axis_tready = !w_full && !i_flush;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_idx_last    = (r_byte_idx == IDX_W'(WORD_BYTES - 1));
  assign w_complete    = w_accept && (w_idx_last || s_axis_tlast);
  assign o_pad_err     = r_pad_err;

  // Merge the incoming byte into its lane; lanes above it are forced to zero for padding.
  always_comb begin
    w_word = r_pack;
    for (int unsigned l = 0; l < WORD_BYTES; l++) begin
      if (IDX_W'(l) == r_byte_idx) begin
        w_word[l*BYTE_W +: BYTE_W] = s_axis_tdata;
      end else if (IDX_W'(l) > r_byte_idx) begin
        w_word[l*BYTE_W +: BYTE_W] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_byte_idx <= '0;
      r_pack     <= '0;
      r_pad_err  <= 1'b0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_byte_idx <= '0;
        r_pack     <= '0;
        if (s_axis_tlast && !w_idx_last) r_pad_err <= 1'b1;
      end else begin
        r_byte_idx <= r_byte_idx + IDX_W'(1);
        r_pack     <= w_word;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_flush),
    .wr_en (w_complete),
    .wdata (DATA_WIDTH'(w_word)),
    .full  (w_full),
    .rd_en (i_fifo_ren),
    .rdata (o_fifo_rdata),
    .empty (o_fifo_empty),
    .count (o_fifo_count)
  );

endmodule

// File: tb/tb_dma_byte_pack_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based packet model.
module tb_dma_byte_pack_fifo;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNT_W = 7;

  logic             clk;
  logic             rst_n;
  logic             i_flush;
  logic [7:0]       s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [31:0]      o_fifo_rdata;
  logic             o_fifo_empty;
  logic             i_fifo_ren;
  logic [CNT_W-1:0] o_fifo_count;
  logic             o_pad_err;

  dma_byte_pack_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .o_fifo_rdata  (o_fifo_rdata),
    .o_fifo_empty  (o_fifo_empty),
    .i_fifo_ren    (i_fifo_ren),
    .o_fifo_count  (o_fifo_count),
    .o_pad_err     (o_pad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: completed words waiting in the FIFO, bytes of the word under construction, sticky pad flag.
  logic [31:0] exp_q[$];
  logic [7:0]  part[$];
  bit          exp_pad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    part.delete();
    exp_pad = 1'b0;
  endtask

  task automatic check_outputs(input bit flush);
    bit exp_ready;
    exp_ready = !flush && (exp_q.size() < DEPTH);
    chk("tready", 32'(s_axis_tready), 32'(exp_ready));
    chk("empty", 32'(o_fifo_empty), 32'(exp_q.size() == 0));
    chk("count", 32'(o_fifo_count), 32'(exp_q.size()));
    chk("rdata", o_fifo_rdata, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk("pad_err", 32'(o_pad_err), 32'(exp_pad));
  endtask

  // One clock: drive inputs, check at the negedge, advance the model, step past the posedge.
  task automatic cycle(input bit flush, input bit valid, input logic [7:0] data,
                       input bit last, input bit ren, output bit acc);
    bit          exp_ready;
    logic [31:0] w;
    i_flush       = flush;
    s_axis_tvalid = valid;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    i_fifo_ren    = ren;
    @(negedge clk);
    check_outputs(flush);
    exp_ready = !flush && (exp_q.size() < DEPTH);
    acc = valid && exp_ready;
    if (flush) begin
      model_clear();
    end else begin
      if (ren && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        part.push_back(data);
        if (part.size() == 4 || last) begin
          if (last && part.size() != 4) exp_pad = 1'b1;
          w = 32'h0;
          foreach (part[k]) w = w | (32'(part[k]) << (8 * k));
          exp_q.push_back(w);
          part.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    i_flush       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h5A;
    s_axis_tlast  = 1'b1;
    i_fifo_ren    = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    bit          acc;
    logic [7:0]  b;
    logic [7:0]  bytes5 [5];
    rst_n = 1'b0;
    i_flush = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h0; s_axis_tlast = 1'b0; i_fifo_ren = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset values
    chk("rst_empty", 32'(o_fifo_empty), 32'h1);
    chk("rst_count", 32'(o_fifo_count), 32'h0);
    chk("rst_rdata", o_fifo_rdata, 32'h0);
    chk("rst_tready", 32'(s_axis_tready), 32'h1);
    chk("rst_pad", 32'(o_pad_err), 32'h0);

    // 1) One aligned packet
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(i + 1), i == 3, 0, acc);
    chk("t1_word", o_fifo_rdata, 32'h04030201);
    chk("t1_empty", 32'(o_fifo_empty), 32'h0);
    chk("t1_pad", 32'(o_pad_err), 32'h0);
    cycle(0, 0, 8'h0, 0, 1, acc);

    // 2) Five-byte packet, padded tail word
    bytes5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) cycle(0, 1, bytes5[i], i == 4, 0, acc);
    chk("t2_head", o_fifo_rdata, 32'hDDCCBBAA);
    chk("t2_pad", 32'(o_pad_err), 32'h1);
    cycle(0, 0, 8'h0, 0, 1, acc);
    chk("t2_tail", o_fifo_rdata, 32'h000000EE);
    cycle(0, 0, 8'h0, 0, 1, acc);
    cycle(1, 0, 8'h0, 0, 0, acc);

    // 3) Fill to full with no reads, then a single pop
    b = 8'h00;
    for (int i = 0; i < 4 * DEPTH + 8; i++) begin
      cycle(0, 1, b, 0, 0, acc);
      if (acc) b = b + 8'h1;
    end
    chk("t3_full_count", 32'(o_fifo_count), 32'(DEPTH));
    chk("t3_full_tready", 32'(s_axis_tready), 32'h0);
    cycle(0, 1, b, 0, 1, acc);
    chk("t3_tready_after_pop", 32'(s_axis_tready), 32'h1);
    cycle(0, 1, b, 0, 0, acc);
    chk("t3_byte_taken", 32'(acc), 32'h1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 8'h0, 0, 1, acc);
    cycle(1, 0, 8'h0, 0, 0, acc);

    // 4) Streaming with ren tracking availability
    for (int i = 0; i < 200; i++) begin
      cycle(0, 1, 8'($urandom), ($urandom % 7) == 0, exp_q.size() != 0, acc);
      chk("t4_count_le2", 32'(o_fifo_count <= 2), 32'h1);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h0, 0, 1, acc);

    // 5) Flush with two words and a partial word in flight
    cycle(1, 0, 8'h0, 0, 0, acc);
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'h30 + i), i == 2, 0, acc);
    cycle(1, 1, 8'h77, 1, 1, acc);
    chk("t5_empty", 32'(o_fifo_empty), 32'h1);
    chk("t5_count", 32'(o_fifo_count), 32'h0);
    chk("t5_pad", 32'(o_pad_err), 32'h0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h90 + i), 0, 0, acc);
    chk("t5_clean_word", o_fifo_rdata, 32'h93929190);
    cycle(0, 0, 8'h0, 0, 1, acc);

    // 6) Reset mid-packet, then read on empty
    cycle(0, 1, 8'h11, 0, 0, acc);
    cycle(0, 1, 8'h22, 0, 0, acc);
    do_reset();
    chk("t6_empty", 32'(o_fifo_empty), 32'h1);
    chk("t6_count", 32'(o_fifo_count), 32'h0);
    chk("t6_rdata", o_fifo_rdata, 32'h0);
    chk("t6_tready", 32'(s_axis_tready), 32'h1);
    cycle(0, 0, 8'h0, 0, 1, acc);
    cycle(0, 0, 8'h0, 0, 1, acc);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'hC0 + i), i == 3, 0, acc);
    chk("t6_fresh_word", o_fifo_rdata, 32'hC3C2C1C0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 60) == 0, ($urandom % 4) != 0, 8'($urandom),
            ($urandom % 6) == 0, ($urandom % 3) == 0, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
